// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: access FSM states, default SRAM base, MEM/WB bundle.
// Used by mem_stage and sram_access_ctrl.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_BASE_DEF = 32'd1024;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [3:0]  dest;
  } mem_wb_t;

  // Byte address relative to the SRAM window, expressed in 32-bit words.
  function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
    return (byte_addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// SRAM bus between the memory stage (master) and the fixed-latency word SRAM (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              sram_we;
  logic              sram_re;
  logic [31:0]       sram_rdata;

  modport master (
    output sram_addr,
    output sram_wdata,
    output sram_we,
    output sram_re,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr,
    input  sram_wdata,
    input  sram_we,
    input  sram_re,
    output sram_rdata
  );
endinterface

// File: rtl/mem_stage_sram_access_ctrl.sv
// Fixed-latency SRAM access sequencer: IDLE -> ACCESS (SRAM_WAIT cycles) -> DONE.
// Latches address/data/direction on launch, drives strobes and captures read data on the last cycle.
module sram_access_ctrl
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int SRAM_WAIT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] word_addr,
  input  logic [31:0]       wdata,
  output logic              freeze,
  output logic              done,
  output logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [31:0]       sram_rdata
);

  localparam int CNT_W = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SRAM_WAIT - 1);

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              store_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       rdata_r;
  logic              last_s;

  assign last_s = (cnt_r == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) state_s = ACCESS;
        else     state_s = IDLE;
      end
      ACCESS: begin
        if (last_s) state_s = DONE;
        else        state_s = ACCESS;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Wait counter, launch-time latches and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      store_r <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            cnt_r   <= '0;
            store_r <= is_store;
            addr_r  <= word_addr;
            wdata_r <= wdata;
          end
        end
        ACCESS: begin
          cnt_r <= cnt_r + CNT_W'(1);
          // A store (including load+store) reports zero as its memory data.
          if (last_s) rdata_r <= store_r ? 32'd0 : sram_rdata;
        end
        default: ;
      endcase
    end
  end

  // Stall and strobe decode; freeze is masked while reset is held.
  always_comb begin
    freeze  = 1'b0;
    done    = 1'b0;
    sram_we = 1'b0;
    sram_re = 1'b0;
    case (state_r)
      IDLE: begin
        if (req && !rst) freeze = 1'b1;
        else             freeze = 1'b0;
      end
      ACCESS: begin
        freeze  = !rst;
        sram_we = store_r;
        sram_re = !store_r;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign rd_data    = rdata_r;
  assign sram_addr  = addr_r;
  assign sram_wdata = wdata_r;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: byte->word address translation, SRAM access via sram_access_ctrl, MEM/WB register.
// Optional one-entry read cache enabled by defining MEM_STAGE_WORD_CACHE_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          SRAM_WAIT = 5,
  parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         WB_EN_In,
  input  logic         MEM_R_EN_In,
  input  logic         MEM_W_EN_In,
  input  logic [31:0]  ALU_Res_In,
  input  logic [31:0]  Val_Rm_In,
  input  logic [3:0]   Dest_In,
  output logic         freeze,
  mem_stage_if.master  sram,
  output logic         WB_EN_Out,
  output logic         MEM_R_EN_Out,
  output logic [31:0]  ALU_Res_Out,
  output logic [31:0]  Mem_Data_Out,
  output logic [3:0]   Dest_Out
);

  logic [ADDR_W-1:0] word_addr_s;
  logic              mem_req_s;
  logic              is_load_s;
  logic              ctrl_req_s;
  logic              hit_s;
  logic [31:0]       hit_data_s;
  logic              freeze_s;
  logic              done_s;
  logic [31:0]       rd_data_s;
  mem_wb_t           mem_wb_r;
  mem_wb_t           mem_wb_s;

  // Out-of-window addresses simply wrap into the SRAM word space.
  assign word_addr_s = ADDR_W'(byte_to_word(ALU_Res_In, ADDR_BASE));
  assign mem_req_s   = MEM_R_EN_In | MEM_W_EN_In;
  assign is_load_s   = MEM_R_EN_In & ~MEM_W_EN_In;
  assign ctrl_req_s  = mem_req_s & ~hit_s;

`ifdef MEM_STAGE_WORD_CACHE_EN
  logic              cache_valid_r;
  logic [ADDR_W-1:0] cache_addr_r;
  logic [31:0]       cache_data_r;
  logic              cache_match_s;

  assign cache_match_s = cache_valid_r && (cache_addr_r == word_addr_s);
  assign hit_s         = is_load_s & cache_match_s;
  assign hit_data_s    = cache_data_r;

  // Cache entry: filled by a load miss, kept coherent by stores to the same word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_r <= 1'b0;
      cache_addr_r  <= '0;
      cache_data_r  <= 32'd0;
    end else if (done_s) begin
      if (is_load_s) begin
        cache_valid_r <= 1'b1;
        cache_addr_r  <= word_addr_s;
        cache_data_r  <= rd_data_s;
      end else if (MEM_W_EN_In && cache_match_s) begin
        cache_data_r  <= Val_Rm_In;
      end
    end
  end
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'd0;
`endif

  sram_access_ctrl #(
    .ADDR_W    (ADDR_W),
    .SRAM_WAIT (SRAM_WAIT)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .req        (ctrl_req_s),
    .is_store   (MEM_W_EN_In),
    .word_addr  (word_addr_s),
    .wdata      (Val_Rm_In),
    .freeze     (freeze_s),
    .done       (done_s),
    .rd_data    (rd_data_s),
    .sram_addr  (sram.sram_addr),
    .sram_wdata (sram.sram_wdata),
    .sram_we    (sram.sram_we),
    .sram_re    (sram.sram_re),
    .sram_rdata (sram.sram_rdata)
  );

  assign freeze = freeze_s;

  // MEM/WB next value: a bubble while stalled so the instruction writes back exactly once.
  always_comb begin
    mem_wb_s = mem_wb_r;
    if (freeze_s) begin
      mem_wb_s.wb_en    = 1'b0;
      mem_wb_s.mem_r_en = 1'b0;
    end else begin
      mem_wb_s.wb_en    = WB_EN_In;
      mem_wb_s.mem_r_en = is_load_s;
      mem_wb_s.alu_res  = ALU_Res_In;
      mem_wb_s.dest     = Dest_In;
      if (done_s)     mem_wb_s.mem_data = rd_data_s;
      else if (hit_s) mem_wb_s.mem_data = hit_data_s;
      else            mem_wb_s.mem_data = 32'd0;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_r <= '0;
    end else begin
      mem_wb_r <= mem_wb_s;
    end
  end

  assign WB_EN_Out    = mem_wb_r.wb_en;
  assign MEM_R_EN_Out = mem_wb_r.mem_r_en;
  assign ALU_Res_Out  = mem_wb_r.alu_res;
  assign Mem_Data_Out = mem_wb_r.mem_data;
  assign Dest_Out     = mem_wb_r.dest;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset corner cases, random traffic vs a word-memory model.
// Define MEM_STAGE_WORD_CACHE_EN to also exercise the read cache.
module tb_mem_stage;
  localparam int SRAM_WAIT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_In, MEM_R_EN_In, MEM_W_EN_In;
  logic [31:0] ALU_Res_In, Val_Rm_In;
  logic [3:0]  Dest_In;
  logic        freeze;
  logic        WB_EN_Out, MEM_R_EN_Out;
  logic [31:0] ALU_Res_Out, Mem_Data_Out;
  logic [3:0]  Dest_Out;

  int checks   = 0;
  int failures = 0;

  mem_stage_if #(.ADDR_W(16)) sram_bus ();

  mem_stage #(.ADDR_W(16), .SRAM_WAIT(SRAM_WAIT), .ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .WB_EN_In(WB_EN_In), .MEM_R_EN_In(MEM_R_EN_In), .MEM_W_EN_In(MEM_W_EN_In),
    .ALU_Res_In(ALU_Res_In), .Val_Rm_In(Val_Rm_In), .Dest_In(Dest_In),
    .freeze(freeze), .sram(sram_bus),
    .WB_EN_Out(WB_EN_Out), .MEM_R_EN_Out(MEM_R_EN_Out), .ALU_Res_Out(ALU_Res_Out),
    .Mem_Data_Out(Mem_Data_Out), .Dest_Out(Dest_Out)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read, write on the clock edge while the strobe is high.
  logic [31:0] sram_mem [0:1023] = '{default: 32'h0};
  assign sram_bus.sram_rdata = sram_mem[sram_bus.sram_addr[9:0]];
  always @(posedge clk) begin
    if (sram_bus.sram_we) sram_mem[sram_bus.sram_addr[9:0]] <= sram_bus.sram_wdata;
  end

  typedef struct {
    logic        wb, r, w;
    logic [31:0] alu, val;
    logic [3:0]  dest;
    int          frz, nre, nwe;
    logic [15:0] addr;
    logic        mr;
    logic [31:0] data;
    logic        chk_data;
  } vec_t;

  // Reference model: architectural word memory plus the one-entry cache contents.
  logic [31:0] model_mem [logic [15:0]];
`ifdef MEM_STAGE_WORD_CACHE_EN
  bit          cv = 1'b0;
  logic [15:0] ca = 16'h0;
`endif

  function automatic logic [31:0] mread(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : 32'h0;
  endfunction

  function automatic logic [15:0] to_word(input logic [31:0] alu);
    logic [31:0] t;
    t = (alu - 32'd1024) >> 2;
    return t[15:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic mk_vec(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] val, input logic [3:0] dest, output vec_t v);
    logic [15:0] wa;
    bit load, hit;
    wa   = to_word(alu);
    load = r && !w;
    hit  = 1'b0;
`ifdef MEM_STAGE_WORD_CACHE_EN
    hit = load && cv && (ca == wa);
`endif
    v.wb = wb; v.r = r; v.w = w; v.alu = alu; v.val = val; v.dest = dest;
    v.frz      = ((r || w) && !hit) ? SRAM_WAIT + 1 : 0;
    v.nre      = (load && !hit) ? SRAM_WAIT : 0;
    v.nwe      = w ? SRAM_WAIT : 0;
    v.addr     = wa;
    v.mr       = load;
    v.data     = load ? mread(wa) : 32'h0;
    v.chk_data = r;
  endtask

  task automatic model_commit(input vec_t v);
    logic [15:0] wa;
    wa = to_word(v.alu);
    if (v.w) model_mem[wa] = v.val;
`ifdef MEM_STAGE_WORD_CACHE_EN
    if (v.r && !v.w) begin
      cv = 1'b1;
      ca = wa;
    end
`endif
  endtask

  // Apply one instruction, hold it through the stall, then check the MEM/WB result.
  task automatic run_vec(input vec_t v, input string tag);
    int frz, nre, nwe;
    bit addr_ok, bub_ok, done;
    frz = 0; nre = 0; nwe = 0; addr_ok = 1'b1; bub_ok = 1'b1; done = 1'b0;
    WB_EN_In = v.wb; MEM_R_EN_In = v.r; MEM_W_EN_In = v.w;
    ALU_Res_In = v.alu; Val_Rm_In = v.val; Dest_In = v.dest;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (sram_bus.sram_re) nre++;
      if (sram_bus.sram_we) nwe++;
      if ((sram_bus.sram_re || sram_bus.sram_we) && sram_bus.sram_addr !== v.addr) addr_ok = 1'b0;
      if (freeze) begin
        frz++;
        if (frz > 1 && WB_EN_Out !== 1'b0) bub_ok = 1'b0;
      end else begin
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_completed"}, 32'(done), 32'd1);
    chk({tag, "_freeze_cycles"}, 32'(frz), 32'(v.frz));
    chk({tag, "_re_cycles"}, 32'(nre), 32'(v.nre));
    chk({tag, "_we_cycles"}, 32'(nwe), 32'(v.nwe));
    if (v.nre + v.nwe > 0) chk({tag, "_sram_addr"}, 32'(addr_ok), 32'd1);
    chk({tag, "_bubble"}, 32'(bub_ok), 32'd1);
    chk({tag, "_wb_en"}, 32'(WB_EN_Out), 32'(v.wb));
    chk({tag, "_mem_r_en"}, 32'(MEM_R_EN_Out), 32'(v.mr));
    chk({tag, "_alu_res"}, ALU_Res_Out, v.alu);
    chk({tag, "_dest"}, 32'(Dest_Out), 32'(v.dest));
    if (v.chk_data) chk({tag, "_mem_data"}, Mem_Data_Out, v.data);
  endtask

  task automatic drive_idle();
    WB_EN_In = 1'b0; MEM_R_EN_In = 1'b0; MEM_W_EN_In = 1'b0;
    ALU_Res_In = 32'h0; Val_Rm_In = 32'h0; Dest_In = 4'h0;
  endtask

  vec_t vecs [9];
  vec_t rv;

  initial begin
    //            wb    r     w     alu            val            dest  frz nre nwe addr      mr    data           chk
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h00000055, 32'h00000000, 4'd3,  0, 0, 0, 16'h0000, 1'b0, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'd1032,     32'hDEADBEEF, 4'd0,  6, 0, 5, 16'h0002, 1'b0, 32'h00000000, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'd1032,     32'h00000000, 4'd5,  6, 5, 0, 16'h0002, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h00001234, 32'h00000000, 4'd7,  0, 0, 0, 16'h0000, 1'b0, 32'h00000000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'd1036,     32'hCAFEF00D, 4'd4,  6, 0, 5, 16'h0003, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'd1036,     32'h00000000, 4'd9,  6, 5, 0, 16'h0003, 1'b1, 32'hCAFEF00D, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'h11112222, 4'd0,  6, 0, 5, 16'hFF00, 1'b0, 32'h00000000, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 4'd1,  6, 5, 0, 16'hFF00, 1'b1, 32'h11112222, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000000, 4'd15, 0, 0, 0, 16'h0000, 1'b0, 32'h00000000, 1'b0};

    // Reset state.
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_sram_re", 32'(sram_bus.sram_re), 32'd0);
    chk("rst_sram_we", 32'(sram_bus.sram_we), 32'd0);
    chk("rst_sram_addr", 32'(sram_bus.sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_bus.sram_wdata, 32'd0);
    chk("rst_wb_en", 32'(WB_EN_Out), 32'd0);
    chk("rst_mem_r_en", 32'(MEM_R_EN_Out), 32'd0);
    chk("rst_alu_res", ALU_Res_Out, 32'd0);
    chk("rst_mem_data", Mem_Data_Out, 32'd0);
    chk("rst_dest", 32'(Dest_Out), 32'd0);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      model_commit(vecs[i]);
    end

    // Reset in the third cycle of a load: abort with no writeback.
    WB_EN_In = 1'b1; MEM_R_EN_In = 1'b1; MEM_W_EN_In = 1'b0;
    ALU_Res_In = 32'd1032; Val_Rm_In = 32'h0; Dest_In = 4'd6;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("abort_re_before_rst", 32'(sram_bus.sram_re), 32'd1);
    chk("abort_freeze_before_rst", 32'(freeze), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_freeze", 32'(freeze), 32'd0);
    chk("abort_sram_re", 32'(sram_bus.sram_re), 32'd0);
    chk("abort_sram_we", 32'(sram_bus.sram_we), 32'd0);
    chk("abort_wb_en", 32'(WB_EN_Out), 32'd0);
    rst = 1'b0;
    drive_idle();
`ifdef MEM_STAGE_WORD_CACHE_EN
    cv = 1'b0;
`endif
    begin
      bit quiet;
      quiet = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (WB_EN_Out !== 1'b0 || freeze !== 1'b0 || sram_bus.sram_re !== 1'b0) quiet = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("abort_no_completion", 32'(quiet), 32'd1);
    end
    mk_vec(1'b1, 1'b0, 1'b0, 32'h00000099, 32'h0, 4'd2, rv);
    run_vec(rv, "post_abort_alu");
    model_commit(rv);

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [31:0] alu;
      kind = $urandom_range(0, 3);
      alu  = (kind == 0) ? $urandom : 32'd1024 + 32'($urandom_range(0, 15) * 4);
      case (kind)
        0:       mk_vec(1'($urandom_range(0, 1)), 1'b0, 1'b0, alu, $urandom, 4'($urandom), rv);
        1, 2:    mk_vec(1'b1, 1'b1, 1'b0, alu, 32'h0, 4'($urandom), rv);
        default: mk_vec(1'b0, 1'b0, 1'b1, alu, $urandom, 4'($urandom), rv);
      endcase
      run_vec(rv, $sformatf("rnd%0d", n));
      model_commit(rv);
    end

`ifdef MEM_STAGE_WORD_CACHE_EN
    // Cache: repeat load hits with no stall; a store updates the cached word.
    mk_vec(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8, rv);
    run_vec(rv, "cache_ld1");
    model_commit(rv);
    mk_vec(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8, rv);
    chk("cache_ld2_expect_hit", 32'(rv.frz), 32'd0);
    run_vec(rv, "cache_ld2");
    model_commit(rv);
    mk_vec(1'b0, 1'b0, 1'b1, 32'd1032, 32'h00000001, 4'd0, rv);
    run_vec(rv, "cache_st");
    model_commit(rv);
    mk_vec(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8, rv);
    run_vec(rv, "cache_ld3");
    model_commit(rv);
    chk("cache_ld3_data", Mem_Data_Out, 32'h00000001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
